// File: rtl/mux_4x1_nbit.sv
// Registered 4-to-1 multiplexer for n-bit words, one cycle of latency.
// Optional registered even-parity output enabled by MUX_4X1_NBIT_PARITY_EN.
module mux_4x1_nbit #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] w0,
  input  logic [n-1:0] w1,
  input  logic [n-1:0] w2,
  input  logic [n-1:0] w3,
  input  logic [1:0]   sel,
`ifdef MUX_4X1_NBIT_PARITY_EN
  output logic         f_par,
`endif
  output logic [n-1:0] f
);

  logic [n-1:0] sel_word;
  logic         sel_known;

  // An X/Z select matches no case item, so sel_known drops and the
  // output register holds; in hardware every code is decoded.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    sel_word  = f;
    sel_known = 1'b0;
    case (sel)
      2'b00: begin sel_word = w0; sel_known = 1'b1; end
      2'b01: begin sel_word = w1; sel_known = 1'b1; end
      2'b10: begin sel_word = w2; sel_known = 1'b1; end
      2'b11: begin sel_word = w3; sel_known = 1'b1; end
      default: ;
    endcase
  end

  // Reset takes priority over selection.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep register updates order-independent.
    if (rst) begin
      f <= '0;
    end else if (sel_known) begin
      f <= sel_word;
    end
  end

`ifdef MUX_4X1_NBIT_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      f_par <= 1'b0;
    end else if (sel_known) begin
      f_par <= ^sel_word;
    end
  end
`endif

endmodule

// File: tb/tb_mux_4x1_nbit.sv
// Directed self-checking bench for mux_4x1_nbit (n = 4 and n = 8 instances).
// Parity checks are built only when MUX_4X1_NBIT_PARITY_EN is defined.
module tb_mux_4x1_nbit;

  logic       clk;
  logic       rst;
  logic [3:0] w0, w1, w2, w3;
  logic [1:0] sel;
  logic [3:0] f;
  logic [7:0] v0, v1, v2, v3;
  logic [1:0] sel8;
  logic [7:0] f8;
`ifdef MUX_4X1_NBIT_PARITY_EN
  logic       f_par;
  logic       f8_par;
`endif

  int checks;
  int errors;

  mux_4x1_nbit #(.n(4)) dut (
    .clk(clk), .rst(rst),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .sel(sel),
`ifdef MUX_4X1_NBIT_PARITY_EN
    .f_par(f_par),
`endif
    .f(f)
  );

  mux_4x1_nbit #(.n(8)) dut8 (
    .clk(clk), .rst(rst),
    .w0(v0), .w1(v1), .w2(v2), .w3(v3),
    .sel(sel8),
`ifdef MUX_4X1_NBIT_PARITY_EN
    .f_par(f8_par),
`endif
    .f(f8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_f(input string name, input logic [3:0] exp);
    checks++;
    if (f !== exp) begin
      errors++;
      $display("FAIL %s: f=%h expected %h", name, f, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 2'b01; w0 = 4'd1; w1 = 4'd9; w2 = 4'd2; w3 = 4'd4;
    sel8 = 2'b10; v0 = 8'h11; v1 = 8'h22; v2 = 8'h33; v3 = 8'h44;
    step();
    expect_f("reset_f", 4'd0);
    checks++;
    if (f8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_f8: f8=%h expected 00", f8);
    end
  endtask

  task automatic test_select_sweep();
    logic [3:0] exp_tab [4];
    exp_tab[0] = 4'd3; exp_tab[1] = 4'd5; exp_tab[2] = 4'd7; exp_tab[3] = 4'd11;
    w0 = 4'd3; w1 = 4'd5; w2 = 4'd7; w3 = 4'd11;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      expect_f($sformatf("sweep_sel%0d", i), exp_tab[i]);
    end
  endtask

  task automatic test_isolation();
    sel = 2'b11;
    step();
    expect_f("iso_hold", 4'd11);
    w0 = 4'd2; step(); expect_f("iso_w0", 4'd11);
    w1 = 4'd4; step(); expect_f("iso_w1", 4'd11);
    w2 = 4'd6; step(); expect_f("iso_w2", 4'd11);
    w3 = 4'd10; step(); expect_f("iso_w3", 4'd10);
  endtask

  task automatic test_reset_priority();
    sel = 2'b10; w2 = 4'd7;
    rst = 1'b1;
    step();
    expect_f("rstpri_clear", 4'd0);
    rst = 1'b0;
    step();
    expect_f("rstpri_resume", 4'd7);
  endtask

  task automatic test_width();
    v0 = 8'hFF; v1 = 8'hA5; v2 = 8'hFF; v3 = 8'hFF;
    sel8 = 2'b01;
    step();
    checks++;
    if (f8 !== 8'hA5) begin
      errors++;
      $display("FAIL width_n8: f8=%h expected a5", f8);
    end
  endtask

  task automatic test_between_edges();
    // A mid-cycle glitch on the selected input must not reach f.
    sel = 2'b00; w0 = 4'd12;
    step();
    w0 = 4'd1;
    #2;
    expect_f("mid_cycle_stable", 4'd12);
    w0 = 4'd12;
    step();
    expect_f("mid_cycle_edge", 4'd12);
  endtask

`ifdef MUX_4X1_NBIT_PARITY_EN
  task automatic expect_par(input string name, input logic exp);
    checks++;
    if (f_par !== exp) begin
      errors++;
      $display("FAIL %s: f_par=%b expected %b", name, f_par, exp);
    end
  endtask

  task automatic test_parity();
    w3 = 4'd11; sel = 2'b11;
    step();
    expect_par("par_1011", 1'b1);
    w0 = 4'd3; sel = 2'b00;
    step();
    expect_par("par_0011", 1'b0);
    w1 = 4'd7; sel = 2'b01;
    step();
    expect_par("par_0111", 1'b1);
    rst = 1'b1;
    step();
    expect_par("par_reset", 1'b0);
    rst = 1'b0;
  endtask
`endif

  task automatic test_unknown_sel();
    // w3 equals w1 so a 2-state simulator resolving x1 to either code
    // still yields the held value.
    w0 = 4'd2; w1 = 4'd5; w2 = 4'd9; w3 = 4'd5;
    sel = 2'b01;
    step();
    expect_f("xsel_setup", 4'd5);
    sel = 2'bx1;
    step();
    expect_f("xsel_hold", 4'd5);
    sel = 2'b10;
    step();
    expect_f("xsel_resume", 4'd9);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_select_sweep();
    test_isolation();
    test_reset_priority();
    test_width();
    test_between_edges();
`ifdef MUX_4X1_NBIT_PARITY_EN
    test_parity();
`endif
    test_unknown_sel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
